sim_sram_tap: RTL and testbench
===============================

Name: sim_sram_tap

Overview:
- Simulation-only TL-UL interceptor placed between a host port (Ibex data/cfg path) and the downstream crossbar.
- Requests whose address falls inside a configurable window go to a small internal SRAM. All other requests pass through unchanged.
- Each accepted write into the window is also exported as a one-cycle strobe. The SW test-status and logging monitor uses this strobe to read software status writes.

Parameters:
- Depth, 32: number of 32-bit words in the window; window size = Depth*4 bytes; must be a power of two.
- MaxOutstanding, 4: maximum in-flight pass-through requests.

Ports:
- clk_sys  in  1  clock
- rst_sys_n  in  1  reset
- start_addr_i  in  32  window base address; Depth*4-byte aligned; quasi-static.
- tl_in_i  in  tl_h2d_t  host request channel.
- tl_in_o  out  tl_d2h_t  host response channel.
- tl_out_o  out  tl_h2d_t  downstream request channel.
- tl_out_i  in  tl_d2h_t  downstream response channel.
- wr_valid_o  out  1  strobe for an accepted in-window write.
- wr_addr_o  out  32  a_address of that write.
- wr_data_o  out  32  a_data of that write.

Behaviour:
- Reset is asynchronous, active-low, rst_sys_n, on clock clk_sys. All state registers clear on reset; SRAM contents are not cleared.
- Reset values: tl_in_o.d_valid=0, tl_out_o.a_valid=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, outstanding count=0.
- Hit rule: hit = (a_address >= start_addr_i) && (a_address < start_addr_i + Depth*4), using 33-bit arithmetic so there is no wrap at 0xFFFF_FFFF.
- Word index = a_address[log2(Depth)+1:2].
- Pass-through path (miss):
  - tl_out_o mirrors tl_in_i combinationally, with a_valid gated by the stall condition.
  - tl_in_o mirrors tl_out_i when no SRAM response is pending.
  - tl_out_o.d_ready = tl_in_i.d_ready.
  - A counter increments on a_valid&&a_ready and decrements on d_valid&&d_ready. Both in the same cycle leaves it unchanged.
  - When the counter equals MaxOutstanding, further miss requests stall.
- SRAM path (hit):
  - The request is accepted (a_ready=1) when the single-entry response register is empty, or is being drained this cycle (d_ready=1).
  - Write opcodes (PutFullData, PutPartialData) update each byte whose a_mask bit is set. The response is AccessAck.
  - Get reads the word; the response is AccessAckData with the stored data.
  - The response is presented with d_valid exactly one cycle after acceptance. It echoes d_source and d_size, with d_error=0 and d_param=0.
  - Response integrity in d_user is generated with the standard TL-UL response integrity generator.
  - A read-after-write to the same word in consecutive cycles returns the new data.
- Ordering: a destination register records the target (SRAM or downstream) of in-flight requests.
  - A request to the other destination stalls (a_ready=0, nothing forwarded) until all in-flight responses drain.
  - Responses therefore return in order. The SRAM response register and tl_out_i.d_valid are never both presented to the host.
- Strobe: wr_valid_o=1 for exactly one cycle, the cycle after a hit write is accepted. wr_addr_o and wr_data_o are registered with the request fields. Reads and misses never strobe.
- Unsupported opcodes to the window are answered with AccessAck and d_error=1; no SRAM update and no strobe.
- d_ready low holds the SRAM response stable until it is consumed.
- Asserting reset mid-transaction drops any pending response; no d_valid is issued after reset.

Test Plan:
- start_addr_i=0x2000_0000. Write 0x0000_900D, mask 0xF, to 0x2000_0000 -> wr_valid_o pulse with wr_addr_o=0x2000_0000 and wr_data_o=0x900D; AccessAck one cycle after acceptance; tl_out_o.a_valid stays 0.
- Read 0x2000_0000 after the above -> AccessAckData with d_data=0x0000_900D and source echoed; no strobe.
- Partial write 0xAABB_CCDD, mask 0x2, to 0x2000_0004 over stored 0x1111_1111 -> read returns 0x1111_CC11.
- Read 0x1000_0000 -> request appears on tl_out_o unchanged; a downstream response with d_data=0x1234_5678 is returned to the host unchanged; no strobe.
- Miss read with downstream response delayed 5 cycles, immediately followed by a hit write -> the hit write stalls until the miss response drains; responses arrive in request order.
- Boundary addresses with Depth=32: 0x2000_007C is a hit; 0x2000_0080 and 0x1FFF_FFFC are misses. Reset asserted while an SRAM response is pending -> d_valid=0 and wr_valid_o=0 after reset.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types, opcodes and response integrity generator
// shared by the SRAM tap and its bench.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] ArithmeticData = 3'h2;
  localparam logic [2:0] LogicalData    = 3'h3;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] Intent         = 3'h5;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [13:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Seven parity checks, each over a rotated copy of a fixed spreading mask.
  function automatic logic [6:0] intg7(input logic [31:0] v);
    logic [31:0] m;
    logic [6:0]  c;
    c = '0;
    for (int k = 0; k < 7; k++) begin
      m = (32'h9E37_79B9 << (5 * k)) | (32'h9E37_79B9 >> (32 - 5 * k));
      c[k] = ^(v & m);
    end
    return c;
  endfunction

  function automatic tl_d_user_t tl_rsp_intg_gen(input logic [2:0] op, input logic [1:0] size,
                                                 input logic err, input logic [31:0] data);
    tl_d_user_t u;
    u.rsp_intg  = intg7({26'b0, op, size, err});
    u.data_intg = intg7(data);
    return u;
  endfunction

endpackage

// File: rtl/sim_sram_tap.sv
// TL-UL interceptor: in-window requests hit a local SRAM and export a write
// strobe; everything else passes through to the crossbar, kept in order.
module sim_sram_tap
  import tlul_pkg::*;
#(
  parameter int Depth          = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic [31:0] start_addr_i,
  input  tl_h2d_t     tl_in_i,
  output tl_d2h_t     tl_in_o,
  output tl_h2d_t     tl_out_o,
  input  tl_d2h_t     tl_out_i,
  output logic        wr_valid_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o
);

  localparam int          AW       = $clog2(Depth);
  localparam int          CW       = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] WinBytes = 33'(Depth * 4);

  logic [31:0]   r_mem [Depth];
  logic [CW-1:0] r_cnt;
  logic          r_rsp_valid;
  logic [2:0]    r_rsp_op;
  logic          r_rsp_err;
  logic [7:0]    r_rsp_src;
  logic [1:0]    r_rsp_size;
  logic [31:0]   r_rsp_data;
  logic          r_wr_valid;
  logic [31:0]   r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_hit, w_hit_ok, w_miss_ok, w_hit_acc;
  logic          w_is_put, w_is_get, w_mem_we, w_up, w_dn;
  logic [32:0]   w_addr33, w_base33;
  logic [AW-1:0] w_idx;
  tl_d_user_t    w_rsp_user;

  // 33-bit compare so a window near the top of memory does not wrap.
  assign w_addr33 = {1'b0, tl_in_i.a_address};
  assign w_base33 = {1'b0, start_addr_i};
  assign w_hit    = (w_addr33 >= w_base33) && (w_addr33 < w_base33 + WinBytes);
  assign w_idx    = tl_in_i.a_address[AW+1:2];

  assign w_is_put = (tl_in_i.a_opcode == PutFullData) || (tl_in_i.a_opcode == PutPartialData);
  assign w_is_get = (tl_in_i.a_opcode == Get);

  // Switching destination waits for every in-flight response to drain.
  assign w_hit_ok  = (r_cnt == '0) && (!r_rsp_valid || tl_in_i.d_ready);
  assign w_miss_ok = !r_rsp_valid && (r_cnt != CW'(MaxOutstanding));
  assign w_hit_acc = tl_in_i.a_valid && w_hit && w_hit_ok;
  assign w_mem_we  = w_hit_acc && w_is_put;

  assign w_up = tl_out_o.a_valid && tl_out_i.a_ready;
  assign w_dn = tl_out_i.d_valid && tl_in_i.d_ready && !r_rsp_valid;

  assign w_rsp_user = tl_rsp_intg_gen(r_rsp_op, r_rsp_size, r_rsp_err, r_rsp_data);

  always_comb begin
    tl_out_o         = tl_in_i;
    tl_out_o.a_valid = tl_in_i.a_valid && !w_hit && w_miss_ok;
  end

  always_comb begin
    tl_in_o = tl_out_i;
    if (r_rsp_valid) begin
      tl_in_o.d_valid  = 1'b1;
      tl_in_o.d_opcode = r_rsp_op;
      tl_in_o.d_param  = 3'b0;
      tl_in_o.d_size   = r_rsp_size;
      tl_in_o.d_source = r_rsp_src;
      tl_in_o.d_sink   = 1'b0;
      tl_in_o.d_data   = r_rsp_data;
      tl_in_o.d_user   = w_rsp_user;
      tl_in_o.d_error  = r_rsp_err;
    end
    tl_in_o.a_ready = w_hit ? w_hit_ok : (tl_out_i.a_ready && w_miss_ok);
  end

  always_ff @(posedge clk_sys) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_we && tl_in_i.a_mask[b]) r_mem[w_idx][8*b +: 8] <= tl_in_i.a_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_op    <= AccessAck;
      r_rsp_err   <= 1'b0;
      r_rsp_src   <= '0;
      r_rsp_size  <= '0;
      r_rsp_data  <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      case ({w_up, w_dn})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_hit_acc) begin
        r_rsp_valid <= 1'b1;
        r_rsp_op    <= w_is_get ? AccessAckData : AccessAck;
        r_rsp_err   <= !(w_is_put || w_is_get);
        r_rsp_src   <= tl_in_i.a_source;
        r_rsp_size  <= tl_in_i.a_size;
        r_rsp_data  <= w_is_get ? r_mem[w_idx] : 32'h0;
      end else if (tl_in_i.d_ready) begin
        r_rsp_valid <= 1'b0;
      end
      r_wr_valid <= w_mem_we;
      if (w_mem_we) begin
        r_wr_addr <= tl_in_i.a_address;
        r_wr_data <= tl_in_i.a_data;
      end
    end
  end

  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;

endmodule

// File: tb/tb_sim_sram_tap.sv
// Bench for sim_sram_tap: directed scenarios plus random traffic checked
// against a word-array model of the window and a scripted downstream.
module tb_sim_sram_tap;
  import tlul_pkg::*;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic [31:0] start_addr;
  tl_h2d_t     h2d;
  tl_d2h_t     host_rsp;
  tl_h2d_t     dn_req;
  tl_d2h_t     dn;
  logic        wr_valid;
  logic [31:0] wr_addr, wr_data;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mdl [0:31];

  sim_sram_tap #(.Depth(32), .MaxOutstanding(4)) dut (
    .clk_sys     (clk_sys),
    .rst_sys_n   (rst_sys_n),
    .start_addr_i(start_addr),
    .tl_in_i     (h2d),
    .tl_in_o     (host_rsp),
    .tl_out_o    (dn_req),
    .tl_out_i    (dn),
    .wr_valid_o  (wr_valid),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until the tap accepts it.
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic [7:0] src, input bit miss);
    int n;
    @(negedge clk_sys);
    h2d.a_valid   = 1'b1;
    h2d.a_opcode  = op;
    h2d.a_size    = 2'd2;
    h2d.a_source  = src;
    h2d.a_address = addr;
    h2d.a_mask    = mask;
    h2d.a_data    = data;
    #1;
    n = 0;
    while (!host_rsp.a_ready && n < 40) begin
      @(negedge clk_sys); #1;
      n++;
    end
    chk("a_ready", 32'(host_rsp.a_ready), 32'd1);
    chk("out_a_valid", 32'(dn_req.a_valid), 32'(miss));
    if (miss) begin
      chk("out_addr", dn_req.a_address, addr);
      chk("out_src", 32'(dn_req.a_source), 32'(src));
    end
    @(posedge clk_sys); #1;
    h2d.a_valid = 1'b0;
  endtask

  // Downstream answers after `delay` negedges; host must see it unchanged.
  task automatic down_rsp(input int delay, input logic [31:0] data, input logic [7:0] src);
    repeat (delay) @(negedge clk_sys);
    dn.d_valid  = 1'b1;
    dn.d_opcode = AccessAckData;
    dn.d_source = src;
    dn.d_data   = data;
    #1;
    chk("dn_d_valid", 32'(host_rsp.d_valid), 32'd1);
    chk("dn_d_data", host_rsp.d_data, data);
    chk("dn_d_src", 32'(host_rsp.d_source), 32'(src));
    chk("dn_no_strobe", 32'(wr_valid), 32'd0);
    @(posedge clk_sys); #1;
    dn.d_valid = 1'b0;
  endtask

  task automatic miss(input logic [31:0] addr, input int delay);
    logic [7:0]  src;
    logic [31:0] data;
    src  = 8'($urandom);
    data = $urandom;
    send(Get, addr, 4'hF, 32'h0, src, 1'b1);
    down_rsp(delay, data, src);
  endtask

  // In-window op: response is checked one cycle after acceptance.
  task automatic hit(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                     input logic [31:0] data);
    logic [7:0]  src;
    logic [31:0] exp_d;
    int          w;
    bit          put, get;
    src = 8'($urandom);
    w   = int'((addr - BASE) >> 2);
    put = (op == PutFullData) || (op == PutPartialData);
    get = (op == Get);
    send(op, addr, mask, data, src, 1'b0);
    exp_d = get ? mdl[w] : 32'h0;
    if (put) for (int b = 0; b < 4; b++) if (mask[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
    chk("d_valid", 32'(host_rsp.d_valid), 32'd1);
    chk("d_opcode", 32'(host_rsp.d_opcode), get ? 32'd1 : 32'd0);
    chk("d_source", 32'(host_rsp.d_source), 32'(src));
    chk("d_error", 32'(host_rsp.d_error), (put || get) ? 32'd0 : 32'd1);
    chk("d_data", host_rsp.d_data, exp_d);
    chk("wr_valid", 32'(wr_valid), 32'(put));
    if (put) begin
      chk("wr_addr", wr_addr, addr);
      chk("wr_data", wr_data, data);
    end
  endtask

  initial begin
    int          k;
    logic [2:0]  op;
    logic [3:0]  mask;
    logic [7:0]  src;
    h2d        = '0;
    dn         = '0;
    dn.a_ready = 1'b1;
    h2d.d_ready = 1'b1;
    start_addr = BASE;
    rst_sys_n  = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_d_valid", 32'(host_rsp.d_valid), 32'd0);
    chk("rst_out_a_valid", 32'(dn_req.a_valid), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;

    // Write then read back, then a partial write over a known word.
    hit(PutFullData, BASE, 4'hF, 32'h0000_900D);
    hit(Get, BASE, 4'hF, 32'h0);
    chk("read_900d", host_rsp.d_data, 32'h0000_900D);
    hit(PutFullData, BASE + 4, 4'hF, 32'h1111_1111);
    hit(PutPartialData, BASE + 4, 4'h2, 32'hAABB_CCDD);
    hit(Get, BASE + 4, 4'hF, 32'h0);
    chk("partial", host_rsp.d_data, 32'h1111_CC11);

    miss(32'h1000_0000, 2);

    // Miss with slow downstream followed by a hit write that must wait.
    src = 8'h5A;
    send(Get, 32'h1000_0000, 4'hF, 32'h0, src, 1'b1);
    @(negedge clk_sys);
    h2d.a_valid = 1'b1; h2d.a_opcode = PutFullData; h2d.a_source = 8'h33;
    h2d.a_address = BASE + 8; h2d.a_mask = 4'hF; h2d.a_data = 32'hCAFE_F00D;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("ord_stall", 32'(host_rsp.a_ready), 32'd0);
      chk("ord_no_fwd", 32'(dn_req.a_valid), 32'd0);
      @(negedge clk_sys);
    end
    dn.d_valid = 1'b1; dn.d_opcode = AccessAckData; dn.d_source = src; dn.d_data = 32'h1234_5678;
    #1;
    chk("ord_first_data", host_rsp.d_data, 32'h1234_5678);
    chk("ord_still_stall", 32'(host_rsp.a_ready), 32'd0);
    @(posedge clk_sys); #1;
    dn.d_valid = 1'b0;
    @(negedge clk_sys); #1;
    chk("ord_accept", 32'(host_rsp.a_ready), 32'd1);
    @(posedge clk_sys); #1;
    h2d.a_valid = 1'b0;
    mdl[2] = 32'hCAFE_F00D;
    chk("ord_second_valid", 32'(host_rsp.d_valid), 32'd1);
    chk("ord_second_src", 32'(host_rsp.d_source), 32'h33);
    chk("ord_strobe", 32'(wr_valid), 32'd1);

    // Window edges.
    hit(PutFullData, BASE + 32'h7C, 4'hF, 32'hBEEF_0001);
    miss(32'h2000_0080, 1);
    miss(32'h1FFF_FFFC, 1);

    // Outstanding limit: the fifth miss stalls until one drains.
    for (int i = 0; i < 4; i++) send(Get, 32'h1000_0100 + 32'(i * 4), 4'hF, 32'h0, 8'(i), 1'b1);
    @(negedge clk_sys);
    h2d.a_valid = 1'b1; h2d.a_address = 32'h1000_0200; h2d.a_opcode = Get;
    #1;
    chk("max_stall", 32'(host_rsp.a_ready), 32'd0);
    chk("max_no_fwd", 32'(dn_req.a_valid), 32'd0);
    h2d.a_valid = 1'b0;
    for (int i = 0; i < 4; i++) down_rsp(1, 32'hD000_0000 + 32'(i), 8'(i));
    miss(32'h1000_0200, 1);

    // Unsupported opcode: error ack, word untouched.
    hit(ArithmeticData, BASE + 8, 4'hF, 32'h0BAD_0BAD);
    hit(Get, BASE + 8, 4'hF, 32'h0);

    // Backpressure holds the SRAM response.
    @(posedge clk_sys); #1;
    h2d.d_ready = 1'b0;
    send(Get, BASE + 4, 4'hF, 32'h0, 8'h11, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", 32'(host_rsp.d_valid), 32'd1);
      chk("hold_data", host_rsp.d_data, mdl[1]);
      @(posedge clk_sys); #1;
    end
    @(negedge clk_sys);
    h2d.d_ready = 1'b1;
    @(posedge clk_sys); #1;
    chk("hold_drained", 32'(host_rsp.d_valid), 32'd0);

    // Random traffic: fill the window, then mix ops.
    for (int i = 0; i < 32; i++) hit(PutFullData, BASE + 32'(i * 4), 4'hF, $urandom);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        miss(32'h3000_0000 + 32'($urandom_range(0, 255) * 4), int'($urandom_range(1, 3)));
      end else begin
        k    = int'($urandom_range(0, 7));
        mask = 4'($urandom);
        op   = (k < 3) ? Get : (k < 5) ? PutFullData : (k < 7) ? PutPartialData :
               (($urandom_range(0, 1) == 0) ? LogicalData : Intent);
        if (op == PutFullData) mask = 4'hF;
        hit(op, BASE + 32'($urandom_range(0, 31) * 4), mask, $urandom);
      end
    end

    // Reset with an SRAM response pending.
    @(posedge clk_sys); #1;
    h2d.d_ready = 1'b0;
    send(PutFullData, BASE + 16, 4'hF, 32'h7777_0000, 8'h22, 1'b0);
    chk("pre_rst_valid", 32'(host_rsp.d_valid), 32'd1);
    rst_sys_n = 1'b0;
    #1;
    chk("mid_rst_d_valid", 32'(host_rsp.d_valid), 32'd0);
    chk("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    @(negedge clk_sys);
    rst_sys_n   = 1'b1;
    h2d.d_ready = 1'b1;
    @(posedge clk_sys); #1;
    chk("post_rst_d_valid", 32'(host_rsp.d_valid), 32'd0);
    chk("post_rst_wr_valid", 32'(wr_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
